// File: rtl/vga_reset_sequencer.sv
// Bring-up sequencer for the VGA datapath: PLL lock -> timed core reset release -> video enable at first vsync.
// Optional build macro VGA_SEQ_LOCK_FILTER_EN adds a consecutive-low glitch filter on the synchronized lock.
module vga_reset_sequencer #(
  parameter int   HOLD_CYCLES        = 1023,
  parameter int   VS_TIMEOUT         = 840000,
  parameter logic VS_ACTIVE          = 1'b0,
  parameter int   CNT_W              = 8,
  parameter int   LOCK_FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             vga_sel_in,
  input  logic             vs,
  output logic             core_rst,
  output logic             out_en,
  output logic             vga_sel,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    ARM       = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TMR_W  = $clog2(VS_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(VS_TIMEOUT - 1);

  if (HOLD_CYCLES < 1 || VS_TIMEOUT < 1 || CNT_W < 1 || LOCK_FILTER_CYCLES < 1) begin : g_param_check
    $error("vga_reset_sequencer: parameters must all be >= 1");
  end

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              core_rst_d, out_en_d, vga_sel_d;
  logic [CNT_W-1:0]  lost_d, timeout_d;
  logic              lock_meta, lock_s, vs_q;
  logic              vs_edge, lock_lost;

  // NOTE: every clocked assignment uses <= so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
      vs_q      <= vs;
    end
  end

  assign vs_edge = (vs_q != VS_ACTIVE) && (vs == VS_ACTIVE);

`ifdef VGA_SEQ_LOCK_FILTER_EN
  localparam int FILT_W = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER_CYCLES - 1);
  logic [FILT_W-1:0] low_cnt;

  // low_cnt holds how many earlier consecutive low samples preceded the current one.
  always_ff @(posedge clk) begin
    if (!rst_n || lock_s) begin
      low_cnt <= '0;
    end else if (low_cnt != FILT_LAST) begin
      low_cnt <= low_cnt + 1'b1;
    end
  end

  assign lock_lost = !lock_s && (low_cnt == FILT_LAST);
`else
  assign lock_lost = !lock_s;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    timer_d    = timer_q;
    core_rst_d = core_rst;
    out_en_d   = out_en;
    vga_sel_d  = vga_sel;
    lost_d     = lost_cnt;
    timeout_d  = timeout_cnt;

    case (state_q)
      WAIT_LOCK: begin
        core_rst_d = 1'b1;
        out_en_d   = 1'b0;
        if (lock_s) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        timer_d = '0;
        if (lock_lost) begin
          state_d    = WAIT_LOCK;
          core_rst_d = 1'b1;
          out_en_d   = 1'b0;
        end else if (hold_q == HOLD_LAST) begin
          state_d    = ARM;
          core_rst_d = 1'b0;
          vga_sel_d  = vga_sel_in;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ARM: begin
        // Lock loss beats a vsync edge, and a vsync edge beats the timeout.
        if (lock_lost) begin
          state_d    = WAIT_LOCK;
          core_rst_d = 1'b1;
          out_en_d   = 1'b0;
          lost_d     = sat_inc(lost_cnt);
        end else if (vs_edge) begin
          state_d  = RUN;
          out_en_d = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          state_d    = HOLD;
          core_rst_d = 1'b1;
          hold_d     = '0;
          timeout_d  = sat_inc(timeout_cnt);
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RUN: begin
        if (lock_lost) begin
          state_d    = WAIT_LOCK;
          core_rst_d = 1'b1;
          out_en_d   = 1'b0;
          lost_d     = sat_inc(lost_cnt);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      hold_q      <= '0;
      timer_q     <= '0;
      core_rst    <= 1'b1;
      out_en      <= 1'b0;
      vga_sel     <= 1'b0;
      lost_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      timer_q     <= timer_d;
      core_rst    <= core_rst_d;
      out_en      <= out_en_d;
      vga_sel     <= vga_sel_d;
      lost_cnt    <= lost_d;
      timeout_cnt <= timeout_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_vga_reset_sequencer.sv
// Self-checking bench for vga_reset_sequencer: directed scenarios plus randomized traffic against a phase-level model.
module tb_vga_reset_sequencer;

  localparam int   HC     = 8;
  localparam int   VT     = 32;
  localparam logic VS_ACT = 1'b0;
  localparam int   LFC    = 4;
  localparam int   MAXC   = 255;
`ifdef VGA_SEQ_LOCK_FILTER_EN
  localparam int DROP = LFC;
`else
  localparam int DROP = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       vga_sel_in;
  logic       vs;
  logic       core_rst;
  logic       out_en;
  logic       vga_sel;
  logic [1:0] state;
  logic [7:0] lost_cnt;
  logic [7:0] timeout_cnt;

  int errors = 0;
  int checks = 0;

  vga_reset_sequencer #(
    .HOLD_CYCLES       (HC),
    .VS_TIMEOUT        (VT),
    .VS_ACTIVE         (VS_ACT),
    .CNT_W             (8),
    .LOCK_FILTER_CYCLES(LFC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .vga_sel_in (vga_sel_in),
    .vs         (vs),
    .core_rst   (core_rst),
    .out_en     (out_en),
    .vga_sel    (vga_sel),
    .state      (state),
    .lost_cnt   (lost_cnt),
    .timeout_cnt(timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase number plus elapsed-cycle count in the current phase.
  int       m_phase, m_elapsed, m_low, m_lost, m_to;
  bit [1:0] m_lock_hist;
  bit       m_vs_prev, m_core_rst, m_out_en, m_sel;

  always @(posedge clk) begin
    bit lk, loss, vedge;
    lk    = m_lock_hist[1];
    vedge = (m_vs_prev != VS_ACT) && (vs == VS_ACT);
    if (!rst_n) begin
      m_lock_hist = '0; m_vs_prev = 1'b0; m_low = 0;
      m_phase = 0; m_elapsed = 0; m_core_rst = 1'b1; m_out_en = 1'b0;
      m_sel = 1'b0; m_lost = 0; m_to = 0;
    end else begin
      m_lock_hist = {m_lock_hist[0], pll_locked};
      m_vs_prev   = vs;
      m_low       = lk ? 0 : m_low + 1;
`ifdef VGA_SEQ_LOCK_FILTER_EN
      loss = (m_low >= LFC);
`else
      loss = !lk;
`endif
      if (m_phase != 0 && loss) begin
        if (m_phase >= 2 && m_lost < MAXC) m_lost++;
        m_phase = 0; m_core_rst = 1'b1; m_out_en = 1'b0;
      end else begin
        case (m_phase)
          0: if (lk) begin m_phase = 1; m_elapsed = 0; end
          1: begin
            m_elapsed++;
            if (m_elapsed == HC) begin
              m_phase = 2; m_elapsed = 0; m_core_rst = 1'b0; m_sel = vga_sel_in;
            end
          end
          2: begin
            m_elapsed++;
            if (vedge) begin
              m_phase = 3; m_out_en = 1'b1;
            end else if (m_elapsed == VT) begin
              m_phase = 1; m_elapsed = 0; m_core_rst = 1'b1;
              if (m_to < MAXC) m_to++;
            end
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [20:0] obs();
    return {state, core_rst, out_en, vga_sel, lost_cnt, timeout_cnt};
  endfunction

  function automatic logic [20:0] mdl();
    return {2'(m_phase), m_core_rst, m_out_en, m_sel, 8'(m_lost), 8'(m_to)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pll_locked = 1'($urandom_range(0, 1));
      vs         = 1'($urandom_range(0, 1));
      vga_sel_in = 1'($urandom_range(0, 1));
      tick(1);
    end
    checks++; if ({state, core_rst, out_en, vga_sel} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_ctrl: got st=%0d rst=%b en=%b sel=%b, want st=0 rst=1 en=0 sel=0", state, core_rst, out_en, vga_sel);
    end
    checks++; if ({lost_cnt, timeout_cnt} !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got lost=%0d to=%0d, want 0 0", lost_cnt, timeout_cnt);
    end
    checks++; if (obs() !== mdl()) begin
      errors++; $display("FAIL reset_model: got %h, want %h", obs(), mdl());
    end
  endtask

  task automatic test_power_up();
    int arm_wait;
    rst_n = 1'b1; pll_locked = 1'b0; vs = 1'b1; vga_sel_in = 1'b1;
    tick(2);
    pll_locked = 1'b1;
    tick(2);
    checks++; if (state !== 2'd0) begin
      errors++; $display("FAIL pwr_sync_delay: got st=%0d, want 0", state);
    end
    tick(1);
    checks++; if ({state, core_rst} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL pwr_hold_entry: got st=%0d rst=%b, want st=1 rst=1", state, core_rst);
    end
    tick(HC - 1);
    checks++; if ({state, core_rst} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL pwr_hold_last: got st=%0d rst=%b, want st=1 rst=1", state, core_rst);
    end
    tick(1);
    checks++; if ({state, core_rst, out_en, vga_sel} !== {2'd2, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL pwr_release: got st=%0d rst=%b en=%b sel=%b, want st=2 rst=0 en=0 sel=1", state, core_rst, out_en, vga_sel);
    end
    arm_wait = $urandom_range(1, 20);
    tick(arm_wait);
    checks++; if ({state, out_en} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL pwr_arm_wait: got st=%0d en=%b, want st=2 en=0", state, out_en);
    end
    vs = 1'b0;
    tick(1);
    checks++; if ({state, out_en, core_rst} !== {2'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL pwr_first_vsync: got st=%0d en=%b rst=%b, want st=3 en=1 rst=0", state, out_en, core_rst);
    end
    checks++; if (obs() !== mdl()) begin
      errors++; $display("FAIL pwr_model: got %h, want %h", obs(), mdl());
    end
  endtask

  task automatic test_pin_map_hold();
    vga_sel_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vs = 1'($urandom_range(0, 1));
      tick(1);
    end
    checks++; if ({state, vga_sel} !== {2'd3, 1'b1}) begin
      errors++; $display("FAIL pinmap_run: got st=%0d sel=%b, want st=3 sel=1", state, vga_sel);
    end
  endtask

  task automatic test_lock_loss_run();
    pll_locked = 1'b0;
    tick(DROP);
    pll_locked = 1'b1; vs = 1'b1;
    tick(2);
    checks++; if ({state, core_rst, out_en, lost_cnt, vga_sel} !== {2'd0, 1'b1, 1'b0, 8'd1, 1'b1}) begin
      errors++; $display("FAIL loss_run: got st=%0d rst=%b en=%b lost=%0d sel=%b, want st=0 rst=1 en=0 lost=1 sel=1",
                         state, core_rst, out_en, lost_cnt, vga_sel);
    end
    tick(1);
    checks++; if (state !== 2'd1) begin
      errors++; $display("FAIL loss_relock: got st=%0d, want 1", state);
    end
    tick(HC - 1);
    checks++; if ({state, core_rst} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL loss_full_hold: got st=%0d rst=%b, want st=1 rst=1", state, core_rst);
    end
    tick(1);
    checks++; if ({state, core_rst, vga_sel} !== {2'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL pinmap_relatch: got st=%0d rst=%b sel=%b, want st=2 rst=0 sel=0", state, core_rst, vga_sel);
    end
  endtask

  task automatic test_missing_vsync();
    vs = 1'b1;
    tick(VT - 1);
    checks++; if ({state, timeout_cnt} !== {2'd2, 8'd0}) begin
      errors++; $display("FAIL vs_timeout_early: got st=%0d to=%0d, want st=2 to=0", state, timeout_cnt);
    end
    tick(1);
    checks++; if ({state, core_rst, out_en, timeout_cnt} !== {2'd1, 1'b1, 1'b0, 8'd1}) begin
      errors++; $display("FAIL vs_timeout: got st=%0d rst=%b en=%b to=%0d, want st=1 rst=1 en=0 to=1",
                         state, core_rst, out_en, timeout_cnt);
    end
  endtask

  task automatic test_vsync_timeout_same_cycle();
    tick(HC);
    checks++; if (state !== 2'd2) begin
      errors++; $display("FAIL tie_rearm: got st=%0d, want 2", state);
    end
    vs = 1'b1;
    tick(VT - 1);
    vs = 1'b0;
    tick(1);
    checks++; if ({state, out_en, timeout_cnt} !== {2'd3, 1'b1, 8'd1}) begin
      errors++; $display("FAIL tie_edge_wins: got st=%0d en=%b to=%0d, want st=3 en=1 to=1", state, out_en, timeout_cnt);
    end
    checks++; if (obs() !== mdl()) begin
      errors++; $display("FAIL tie_model: got %h, want %h", obs(), mdl());
    end
  endtask

  task automatic test_loss_in_hold();
    pll_locked = 1'b0;
    tick(DROP);
    pll_locked = 1'b1;
    tick(3);
    checks++; if ({state, lost_cnt} !== {2'd1, 8'd2}) begin
      errors++; $display("FAIL hold_setup: got st=%0d lost=%0d, want st=1 lost=2", state, lost_cnt);
    end
    pll_locked = 1'b0;
    tick(DROP);
    pll_locked = 1'b1;
    tick(2);
    checks++; if ({state, core_rst, lost_cnt} !== {2'd0, 1'b1, 8'd2}) begin
      errors++; $display("FAIL hold_loss: got st=%0d rst=%b lost=%0d, want st=0 rst=1 lost=2", state, core_rst, lost_cnt);
    end
    tick(1);
    checks++; if (state !== 2'd1) begin
      errors++; $display("FAIL hold_relock: got st=%0d, want 1", state);
    end
  endtask

`ifdef VGA_SEQ_LOCK_FILTER_EN
  task automatic test_filter();
    vs = 1'b1;
    tick(HC);
    vs = 1'b0;
    tick(1);
    pll_locked = 1'b0;
    tick(LFC - 1);
    pll_locked = 1'b1;
    tick(6);
    checks++; if ({state, out_en, lost_cnt} !== {2'd3, 1'b1, 8'd2}) begin
      errors++; $display("FAIL filter_short: got st=%0d en=%b lost=%0d, want st=3 en=1 lost=2", state, out_en, lost_cnt);
    end
    pll_locked = 1'b0;
    tick(LFC);
    pll_locked = 1'b1;
    tick(2);
    checks++; if ({state, out_en, lost_cnt} !== {2'd0, 1'b0, 8'd3}) begin
      errors++; $display("FAIL filter_long: got st=%0d en=%b lost=%0d, want st=0 en=0 lost=3", state, out_en, lost_cnt);
    end
  endtask
`endif

  task automatic test_random();
    int toggle_div, drop_left;
    drop_left = 0;
    for (int seg = 0; seg < 4; seg++) begin
      toggle_div = (seg % 2 == 0) ? 4 : 60;
      for (int i = 0; i < 150; i++) begin
        checks++; if (obs() !== mdl()) begin
          errors++; $display("FAIL random seg%0d cyc%0d: got %h, want %h", seg, i, obs(), mdl());
        end
        rst_n = ($urandom_range(0, 199) != 0);
        if (drop_left > 0) begin
          pll_locked = 1'b0; drop_left--;
        end else begin
          pll_locked = 1'b1;
          if ($urandom_range(0, 49) == 0) drop_left = $urandom_range(1, 6);
        end
        if ($urandom_range(0, toggle_div - 1) == 0) vs = ~vs;
        vga_sel_in = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1; pll_locked = 1'b1; vs = 1'b1;
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (state !== 2'd2 && n < 200) begin tick(1); n++; end
      if (state !== 2'd2) begin
        checks++; errors++;
        $display("FAIL sat_wait_arm: iteration %0d got st=%0d, want 2 within 200 cycles", i, state);
      end
      if (i == 200) begin
        checks++; if (lost_cnt !== 8'd200) begin
          errors++; $display("FAIL sat_mid: got lost=%0d, want 200", lost_cnt);
        end
      end
      vs = 1'b0;
      tick(1);
      vs = 1'b1;
      pll_locked = 1'b0;
      tick(DROP);
      pll_locked = 1'b1;
    end
    tick(2);
    checks++; if ({state, lost_cnt} !== {2'd0, 8'd255}) begin
      errors++; $display("FAIL sat_final: got st=%0d lost=%0d, want st=0 lost=255", state, lost_cnt);
    end
    checks++; if (obs() !== mdl()) begin
      errors++; $display("FAIL sat_model: got %h, want %h", obs(), mdl());
    end
  endtask

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; vs = 1'b1; vga_sel_in = 1'b0;
    tick(1);
    test_reset();
    test_power_up();
    test_pin_map_hold();
    test_lock_loss_run();
    test_missing_vsync();
    test_vsync_timeout_same_cycle();
    test_loss_in_hold();
`ifdef VGA_SEQ_LOCK_FILTER_EN
    test_filter();
`endif
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary line");
    $fatal(1, "watchdog expired");
  end

endmodule
